// File: rtl/vga_text_pkg.sv
// Shared constants, command encoding and engine states for the VGA text buffer controller.
package vga_text_pkg;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    localparam logic [15:0] FILL_CELL = 16'h0F20;

    localparam logic CMD_CLEAR  = 1'b0;
    localparam logic CMD_SCROLL = 1'b1;

    // Bit positions in the one-hot arbiter grant
    localparam int GNT_FETCH = 0;
    localparam int GNT_CPU   = 1;
    localparam int GNT_ENG   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR_WR,
        ST_SCR_RD,
        ST_SCR_WAIT,
        ST_SCR_WR,
        ST_SCR_CLR,
        ST_DONE
    } eng_state_e;
endpackage

// File: rtl/vga_text_buf_ctrl_arb.sv
// Fetch-first arbiter; CPU and engine share the leftover slots round-robin.
module vga_text_arb
    import vga_text_pkg::*;
(
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_fetch_req,
    input  logic       I_cpu_req,
    input  logic       I_eng_req,
    output logic [2:0] O_gnt
);

    // eng_first_q set means the CPU was served last, so the engine wins a tie
    logic eng_first_q;
    logic eng_first_d;

    always_comb begin
        O_gnt       = '0;
        eng_first_d = eng_first_q;
        if (I_fetch_req) begin
            O_gnt[GNT_FETCH] = 1'b1;
        end else if (I_cpu_req && I_eng_req) begin
            if (eng_first_q) begin
                O_gnt[GNT_ENG] = 1'b1;
            end else begin
                O_gnt[GNT_CPU] = 1'b1;
            end
        end else if (I_cpu_req) begin
            O_gnt[GNT_CPU] = 1'b1;
        end else if (I_eng_req) begin
            O_gnt[GNT_ENG] = 1'b1;
        end
        if (O_gnt[GNT_CPU]) begin
            eng_first_d = 1'b1;
        end
        if (O_gnt[GNT_ENG]) begin
            eng_first_d = 1'b0;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            eng_first_q <= 1'b0;
        end else begin
            eng_first_q <= eng_first_d;
        end
    end

endmodule

// File: rtl/vga_text_buf_ctrl.sv
// Character RAM owner for the VGA text console: fetch pipe, CPU writes and clear/scroll engine.
//
// state       | meaning
// ST_IDLE     | waiting for a command, O_cmd_ready high
// ST_CLR_WR   | writing FILL_CELL to every cell, one per engine grant
// ST_SCR_RD   | reading source cell d+COLS
// ST_SCR_WAIT | two cycles after the read grant, latch the RAM data
// ST_SCR_WR   | writing the latched cell to destination d
// ST_SCR_CLR  | filling the last row with FILL_CELL
// ST_DONE     | one-cycle completion pulse
module vga_text_buf_ctrl
    import vga_text_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_fetch_req,
    input  logic [AW-1:0] I_fetch_addr,
    output logic          O_fetch_valid,
    output logic [DW-1:0] O_fetch_data,
    input  logic          I_cpu_valid,
    input  logic [AW-1:0] I_cpu_addr,
    input  logic [DW-1:0] I_cpu_wdata,
    output logic          O_cpu_ready,
    input  logic          I_cmd_valid,
    input  logic          I_cmd,
    output logic          O_cmd_ready,
    output logic          O_busy,
    output logic          O_done,
    output logic          O_ram_en,
    output logic          O_ram_we,
    output logic [AW-1:0] O_ram_addr,
    output logic [DW-1:0] O_ram_wdata,
    input  logic [DW-1:0] I_ram_rdata
);

    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_COPY = AW'(COLS * (ROWS - 1) - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);
    localparam logic [DW-1:0] FILL      = DW'(FILL_CELL);

    eng_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cell_q, cell_d;
    logic          wait_q, wait_d;

    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;

    logic          fv1_q, fv2_q;
    logic          fetch_valid_q;
    logic [DW-1:0] fetch_data_q, fetch_data_d;

    logic          eng_req, eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic [2:0]    gnt;
    logic          cpu_in_range;
    logic          cpu_wr;

    vga_text_arb u_arb (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_fetch_req (I_fetch_req),
        .I_cpu_req   (I_cpu_valid),
        .I_eng_req   (eng_req),
        .O_gnt       (gnt)
    );

    assign cpu_in_range = (I_cpu_addr <= LAST_CELL);
    assign cpu_wr       = gnt[GNT_CPU] && cpu_in_range;

    always_comb begin
        eng_req   = 1'b0;
        eng_we    = 1'b1;
        eng_addr  = cnt_q;
        eng_wdata = FILL;
        case (state_q)
            ST_CLR_WR, ST_SCR_CLR: eng_req = 1'b1;
            ST_SCR_RD: begin
                eng_req  = 1'b1;
                eng_we   = 1'b0;
                eng_addr = cnt_q + ROW_STEP;
            end
            ST_SCR_WR: begin
                eng_req   = 1'b1;
                eng_wdata = cell_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cell_d  = cell_q;
        wait_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_cmd_valid) begin
                    cnt_d   = '0;
                    state_d = (I_cmd == CMD_SCROLL) ? ST_SCR_RD : ST_CLR_WR;
                end
            end
            ST_CLR_WR, ST_SCR_CLR: begin
                if (gnt[GNT_ENG]) begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_SCR_RD: begin
                if (gnt[GNT_ENG]) begin
                    state_d = ST_SCR_WAIT;
                end
            end
            // Fixed two-cycle wait: the read data is ours even if fetch took the port meanwhile
            ST_SCR_WAIT: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    cell_d  = I_ram_rdata;
                    state_d = ST_SCR_WR;
                end
            end
            ST_SCR_WR: begin
                if (gnt[GNT_ENG]) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_COPY) ? ST_SCR_CLR : ST_SCR_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Out-of-range CPU writes are granted but never reach the RAM
    always_comb begin
        ram_en_d    = gnt[GNT_FETCH] || gnt[GNT_ENG] || cpu_wr;
        ram_we_d    = cpu_wr || (gnt[GNT_ENG] && eng_we);
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (gnt[GNT_FETCH]) begin
            ram_addr_d = I_fetch_addr;
        end else if (cpu_wr) begin
            ram_addr_d  = I_cpu_addr;
            ram_wdata_d = I_cpu_wdata;
        end else if (gnt[GNT_ENG]) begin
            ram_addr_d = eng_addr;
            if (eng_we) begin
                ram_wdata_d = eng_wdata;
            end
        end
        fetch_data_d = fv2_q ? I_ram_rdata : fetch_data_q;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cell_q        <= '0;
            wait_q        <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            fv1_q         <= 1'b0;
            fv2_q         <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cell_q        <= cell_d;
            wait_q        <= wait_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            fv1_q         <= gnt[GNT_FETCH];
            fv2_q         <= fv1_q;
            fetch_valid_q <= fv2_q;
            fetch_data_q  <= fetch_data_d;
        end
    end

    assign O_cpu_ready   = gnt[GNT_CPU];
    assign O_cmd_ready   = (state_q == ST_IDLE);
    assign O_busy        = (state_q != ST_IDLE);
    assign O_done        = (state_q == ST_DONE);
    assign O_ram_en      = ram_en_q;
    assign O_ram_we      = ram_we_q;
    assign O_ram_addr    = ram_addr_q;
    assign O_ram_wdata   = ram_wdata_q;
    assign O_fetch_valid = fetch_valid_q;
    assign O_fetch_data  = fetch_data_q;

endmodule
